// File: rtl/mem_wr_sink.sv
// mem_wr_sink: consumer of the memory write bus. Every qualified write lands
// in a 2**AW-entry register bank and is queued, in order, in a DEPTH-entry
// show-ahead FIFO that drains over a valid/ready stream. A registered
// readback port returns bank contents with one cycle of latency.
module mem_wr_sink #(
  parameter int BW    = 8,
  parameter int AW    = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mem_wr_en,
  input  logic [AW-1:0]              mem_addr,
  input  logic [BW-1:0]              mem_data,
  input  logic [AW-1:0]              rd_addr,
  output logic [BW-1:0]              rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [AW-1:0]              out_addr,
  output logic [BW-1:0]              out_data,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       ovf,
  input  logic                       ovf_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = AW + BW;

  logic [BW-1:0] bank [2**AW];
  logic [RW-1:0] fifo_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic          pop;
  logic          full;
  logic          accept;
  logic          drop;
  logic [PW-1:0] rd_ptr_nxt;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_nxt;
  logic          head_load;
  logic [RW-1:0] head_nxt;

  assign out_valid = (fifo_count != '0);

  // Push/pop decisions and the record that becomes the head after this edge.
  always_comb begin
    pop        = out_valid && out_ready;
    full       = (fifo_count == CW'(DEPTH));
    // A full FIFO still takes the push when the head leaves in the same cycle.
    accept     = mem_wr_en && (!full || pop);
    drop       = mem_wr_en && full && !pop;
    rd_ptr_nxt = pop ? (rd_ptr + PW'(1)) : rd_ptr;
    remain     = fifo_count - CW'(pop);
    count_nxt  = remain + CW'(accept);
    head_load  = 1'b0;
    head_nxt   = {out_addr, out_data};
    if (remain != '0) begin
      // Entry at the new read pointer is older than any write this cycle.
      head_load = 1'b1;
      head_nxt  = fifo_mem[rd_ptr_nxt];
    end else if (accept) begin
      // FIFO drains to empty (or was empty): the incoming write becomes head.
      head_load = 1'b1;
      head_nxt  = {mem_addr, mem_data};
    end
  end

  // Register bank update and write-first readback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2**AW; i++) bank[i] <= '0;
      rd_data <= '0;
    end else begin
      if (mem_wr_en) bank[mem_addr] <= mem_data;
      if (mem_wr_en && (mem_addr == rd_addr)) rd_data <= mem_data;
      else                                    rd_data <= bank[rd_addr];
    end
  end

  // FIFO storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (accept) fifo_mem[wr_ptr] <= {mem_addr, mem_data};
  end

  // FIFO pointers, occupancy and registered head record.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr     <= rd_ptr_nxt;
      fifo_count <= count_nxt;
      if (head_load) {out_addr, out_data} <= head_nxt;
    end
  end

  // Sticky overflow flag; a drop in the same cycle wins over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule

// File: tb/tb_mem_wr_sink.sv
// tb_mem_wr_sink: directed bench for mem_wr_sink with hand-computed expectations.
module tb_mem_wr_sink;

  localparam int BW = 8;
  localparam int AW = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_wr_en;
  logic [AW-1:0] mem_addr;
  logic [BW-1:0] mem_data;
  logic [AW-1:0] rd_addr;
  logic [BW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [BW-1:0] out_data;
  logic [2:0]    fifo_count;
  logic          ovf;
  logic          ovf_clr;

  int n_cmp = 0;
  int n_err = 0;

  mem_wr_sink #(.BW(BW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
    .mem_data(mem_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .fifo_count(fifo_count), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [BW-1:0] d);
    mem_wr_en = 1'b1; mem_addr = a; mem_data = d;
    tick();
    mem_wr_en = 1'b0; mem_addr = '0; mem_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_wr_en = 1'b0; mem_addr = '0; mem_data = '0;
    rd_addr = '0; out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d want=0", fifo_count); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%0b want=0", ovf); end
    n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL reset_rd got=%h want=00", rd_data); end
    n_cmp++; if ({out_addr, out_data} !== 10'h000) begin n_err++; $display("FAIL reset_head got=%h want=000", {out_addr, out_data}); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1; rd_addr = 2'd2;
    wr(2'd2, 8'hA5);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid got=%0b want=1", out_valid); end
    n_cmp++; if (out_addr !== 2'd2) begin n_err++; $display("FAIL basic_addr got=%0d want=2", out_addr); end
    n_cmp++; if (out_data !== 8'hA5) begin n_err++; $display("FAIL basic_data got=%h want=a5", out_data); end
    n_cmp++; if (rd_data !== 8'hA5) begin n_err++; $display("FAIL basic_rd got=%h want=a5", rd_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_overflow();
    logic [BW-1:0] exp_d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready = 1'b0;
    wr(2'd0, 8'h11); wr(2'd1, 8'h22); wr(2'd2, 8'h33); wr(2'd3, 8'h44);
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_at_full got=%0b want=0", ovf); end
    wr(2'd0, 8'h55);
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL ovf_count got=%0d want=4", fifo_count); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%0b want=1", ovf); end
    n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL ovf_hold got=%h want=11", out_data); end
    rd_addr = 2'd0;
    tick();
    n_cmp++; if (rd_data !== 8'h55) begin n_err++; $display("FAIL ovf_bank0 got=%h want=55", rd_data); end
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got=%0b want=1", ovf); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_addr !== 2'(i))
        begin n_err++; $display("FAIL drain%0d got=%0b/%0d/%h want=1/%0d/%h", i, out_valid, out_addr, out_data, i, exp_d[i]); end
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain_end got=%0b want=0", out_valid); end
    out_ready = 1'b0; ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clear got=%0b want=0", ovf); end
  endtask

  task automatic test_full_push_pop();
    logic [BW-1:0] exp_d [4] = '{8'h72, 8'h73, 8'h74, 8'h66};
    out_ready = 1'b0;
    wr(2'd0, 8'h71); wr(2'd1, 8'h72); wr(2'd2, 8'h73); wr(2'd3, 8'h74);
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL fpp_full got=%0d want=4", fifo_count); end
    out_ready = 1'b1;
    wr(2'd1, 8'h66);
    n_cmp++; if (fifo_count !== 3'd4) begin n_err++; $display("FAIL fpp_count got=%0d want=4", fifo_count); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL fpp_ovf got=%0b want=0", ovf); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_d[i])
        begin n_err++; $display("FAIL fpp_drain%0d got=%0b/%h want=1/%h", i, out_valid, out_data, exp_d[i]); end
      tick();
    end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL fpp_end got=%0d want=0", fifo_count); end
  endtask

  task automatic test_write_first_and_nonfull();
    out_ready = 1'b0; rd_addr = 2'd1;
    wr(2'd1, 8'h3C);
    n_cmp++; if (rd_data !== 8'h3C) begin n_err++; $display("FAIL wf_rd got=%h want=3c", rd_data); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL wf_count got=%0d want=1", fifo_count); end
    out_ready = 1'b1;
    wr(2'd2, 8'h5A);
    n_cmp++; if (fifo_count !== 3'd1) begin n_err++; $display("FAIL nf_count got=%0d want=1", fifo_count); end
    n_cmp++; if (out_addr !== 2'd2 || out_data !== 8'h5A) begin n_err++; $display("FAIL nf_head got=%0d/%h want=2/5a", out_addr, out_data); end
    n_cmp++; if (rd_data !== 8'h3C) begin n_err++; $display("FAIL nf_rd got=%h want=3c", rd_data); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nf_empty got=%0b want=0", out_valid); end
  endtask

  task automatic test_ovf_set_beats_clr();
    out_ready = 1'b0;
    wr(2'd0, 8'h01); wr(2'd1, 8'h02); wr(2'd2, 8'h03); wr(2'd3, 8'h04);
    ovf_clr = 1'b1;
    wr(2'd0, 8'h05);
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b1) begin n_err++; $display("FAIL ovf_prio got=%0b want=1", ovf); end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ovf_clr_alone got=%0b want=0", ovf); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    wr(2'd1, 8'h06);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (fifo_count !== 3'd3 || ovf !== 1'b1) begin n_err++; $display("FAIL ar_pre got=%0d/%0b want=3/1", fifo_count, ovf); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ar_valid got=%0b want=0", out_valid); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_err++; $display("FAIL ar_count got=%0d want=0", fifo_count); end
    n_cmp++; if (ovf !== 1'b0) begin n_err++; $display("FAIL ar_ovf got=%0b want=0", ovf); end
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      tick();
      n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL ar_bank%0d got=%h want=00", i, rd_data); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_push_pop();
    test_write_first_and_nonfull();
    test_ovf_set_beats_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
